// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads 8-bit instruction words over a
// req/ack memory port, and holds them in an IR. Decode consumes the IR through
// an instr_valid/instr_ready handshake. Jump/branch redirects overwrite the PC.
// A memory request that waits too long for an ack sends the stage into a
// sticky error state, and only reset clears that state.

module instruction_fetch #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  TIMEOUT  = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fetch_en,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_ack,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [1:0]          Opcode,
  output logic [2:0]          Funct,
  output logic [2:0]          operand,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                fetch_err
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_VALID = 2'd1,
    ST_IDLE  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [7:0]          TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [PC_WIDTH-1:0] PC_ONE    = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic [7:0]          ir_r;
  logic [PC_WIDTH-1:0] instr_pc_r;
  logic [7:0]          wait_cnt_r;

  // Fetch control FSM: state, PC, IR and wait counter advance together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_REQ;
      pc_r       <= RESET_PC;
      ir_r       <= 8'h00;
      instr_pc_r <= '0;
      wait_cnt_r <= 8'd0;
    end else if (redirect && (state_r != ST_ERR)) begin
      // Redirect wins over everything. A same-cycle ack is dropped, and any
      // in-flight request is simply abandoned.
      pc_r       <= redirect_pc;
      wait_cnt_r <= 8'd0;
      state_r    <= fetch_en ? ST_REQ : ST_IDLE;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (!fetch_en) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 8'd0;
          end else if (mem_ack) begin
            ir_r       <= mem_rdata;
            instr_pc_r <= pc_r;
            pc_r       <= pc_r + PC_ONE;
            wait_cnt_r <= 8'd0;
            state_r    <= ST_VALID;
          end else if (wait_cnt_r == TIMEOUT_C) begin
            state_r    <= ST_ERR;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_VALID: begin
          if (instr_ready) begin
            state_r <= fetch_en ? ST_REQ : ST_IDLE;
          end else begin
            state_r <= ST_VALID;
          end
        end
        ST_IDLE: begin
          if (fetch_en) begin
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ERR: begin
          state_r <= ST_ERR;
        end
        default: begin
          state_r <= ST_ERR;
        end
      endcase
    end
  end

  // mem_req is gated by reset so that it drops as soon as reset rises, not at
  // the next clock edge.
  assign mem_req     = (state_r == ST_REQ) && fetch_en && !reset;
  assign mem_addr    = pc_r;
  assign instr_valid = (state_r == ST_VALID);
  assign fetch_err   = (state_r == ST_ERR);
  assign Opcode      = ir_r[7:6];
  assign Funct       = ir_r[5:3];
  assign operand     = ir_r[2:0];
  assign instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch. Inputs change on the falling edge.
// Outputs are sampled on the falling edge, half a cycle after the DUT's
// rising-edge update.

module tb_instruction_fetch;

  logic       clock = 1'b0;
  logic       reset;
  logic       fetch_en;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] Opcode;
  logic [2:0] Funct;
  logic [2:0] operand;
  logic [7:0] instr_pc;
  logic       fetch_err;

  int vectors = 0;
  int miscompares = 0;

  instruction_fetch #(.PC_WIDTH(8), .RESET_PC(8'h00), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Opcode(Opcode), .Funct(Funct), .operand(operand),
    .instr_pc(instr_pc), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_en = 1'b1; mem_rdata = 8'h00; mem_ack = 1'b0;
    redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
    tick(); tick();
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b exp 0", fetch_err); end
    vectors++; if ({Opcode, Funct, operand} !== 8'h00) begin miscompares++; $display("FAIL rst_ir got %h exp 00", {Opcode, Funct, operand}); end
    vectors++; if (instr_pc !== 8'h00) begin miscompares++; $display("FAIL rst_instr_pc got %h exp 00", instr_pc); end
    reset = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin miscompares++; $display("FAIL rst_first_req got %b/%h exp 1/00", mem_req, mem_addr); end
  endtask

  task automatic test_zero_wait();
    @(negedge clock);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL zw_valid got %b exp 1", instr_valid); end
    vectors++; if (Opcode !== 2'b01) begin miscompares++; $display("FAIL zw_opcode got %b exp 01", Opcode); end
    vectors++; if (Funct !== 3'b011) begin miscompares++; $display("FAIL zw_funct got %b exp 011", Funct); end
    vectors++; if (operand !== 3'b010) begin miscompares++; $display("FAIL zw_operand got %b exp 010", operand); end
    vectors++; if (instr_pc !== 8'h00) begin miscompares++; $display("FAIL zw_instr_pc got %h exp 00", instr_pc); end
    vectors++; if (mem_addr !== 8'h01 || mem_req !== 1'b0) begin miscompares++; $display("FAIL zw_pc got %h/%b exp 01/0", mem_addr, mem_req); end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL stall_ctrl cyc %0d got %b/%b exp 1/0", i, instr_valid, mem_req); end
      vectors++; if ({Opcode, Funct, operand} !== 8'h5A) begin miscompares++; $display("FAIL stall_ir cyc %0d got %h exp 5a", i, {Opcode, Funct, operand}); end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    vectors++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h01) begin miscompares++; $display("FAIL stall_release got v%b r%b a%h exp v0 r1 a01", instr_valid, mem_req, mem_addr); end
  endtask

  task automatic test_back_to_back();
    instr_ready = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'hC7;
    tick();
    mem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 8'h01 || {Opcode, Funct, operand} !== 8'hC7) begin miscompares++; $display("FAIL b2b_first got v%b pc%h ir%h exp v1 pc01 irc7", instr_valid, instr_pc, {Opcode, Funct, operand}); end
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 8'h02) begin miscompares++; $display("FAIL b2b_req got %b/%h exp 1/02", mem_req, mem_addr); end
    tick();
    mem_ack = 1'b0; instr_ready = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 8'h02 || Opcode !== 2'b00 || Funct !== 3'b111 || operand !== 3'b100) begin miscompares++; $display("FAIL b2b_second got v%b pc%h ir%h exp v1 pc02 ir3c", instr_valid, instr_pc, {Opcode, Funct, operand}); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect = 1'b0;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 8'hFF) begin miscompares++; $display("FAIL wrap_req got %b/%h exp 1/ff", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 8'h81;
    tick();
    mem_ack = 1'b0;
    vectors++; if (instr_pc !== 8'hFF || mem_addr !== 8'h00) begin miscompares++; $display("FAIL wrap_pc got ipc%h pc%h exp ipcff pc00", instr_pc, mem_addr); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin miscompares++; $display("FAIL wrap_next got %b/%h exp 1/00", mem_req, mem_addr); end
  endtask

  task automatic test_redirect();
    mem_ack = 1'b1; mem_rdata = 8'hFF; redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    mem_ack = 1'b0; redirect = 1'b0;
    vectors++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h40) begin miscompares++; $display("FAIL redir_ack got v%b r%b a%h exp v0 r1 a40", instr_valid, mem_req, mem_addr); end
    vectors++; if ({Opcode, Funct, operand} !== 8'h81 || instr_pc !== 8'hFF) begin miscompares++; $display("FAIL redir_drop got ir%h pc%h exp ir81 pcff", {Opcode, Funct, operand}, instr_pc); end
    mem_ack = 1'b1; mem_rdata = 8'h12;
    tick();
    mem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 8'h40) begin miscompares++; $display("FAIL redir_fetch got v%b pc%h exp v1 pc40", instr_valid, instr_pc); end
    redirect = 1'b1; redirect_pc = 8'h20; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    vectors++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h20) begin miscompares++; $display("FAIL redir_valid got v%b r%b a%h exp v0 r1 a20", instr_valid, mem_req, mem_addr); end
  endtask

  task automatic test_idle();
    fetch_en = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL idle_gate got %b exp 0", mem_req); end
    tick(); tick(); tick();
    vectors++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 8'h20) begin miscompares++; $display("FAIL idle_hold got r%b v%b a%h exp r0 v0 a20", mem_req, instr_valid, mem_addr); end
    fetch_en = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL idle_pre got %b exp 0", mem_req); end
    tick();
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 8'h20) begin miscompares++; $display("FAIL idle_resume got %b/%h exp 1/20", mem_req, mem_addr); end
  endtask

  task automatic test_timeout();
    // REQ was entered with the counter at 0; the 16th ack-less edge (counter == 15) errors.
    for (int i = 0; i < 15; i++) tick();
    vectors++; if (fetch_err !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h20) begin miscompares++; $display("FAIL to_early got e%b r%b a%h exp e0 r1 a20", fetch_err, mem_req, mem_addr); end
    tick();
    vectors++; if (fetch_err !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL to_err got e%b r%b exp e1 r0", fetch_err, mem_req); end
    redirect = 1'b1; redirect_pc = 8'h10; mem_ack = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    redirect = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    vectors++; if (fetch_err !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 8'h20) begin miscompares++; $display("FAIL to_sticky got e%b r%b v%b a%h exp e1 r0 v0 a20", fetch_err, mem_req, instr_valid, mem_addr); end
  endtask

  task automatic test_reset_mid_request();
    #2 reset = 1'b1;
    #1;
    vectors++; if (fetch_err !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 8'h00) begin miscompares++; $display("FAIL rerst_err got e%b r%b a%h exp e0 r0 a00", fetch_err, mem_req, mem_addr); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin miscompares++; $display("FAIL rerst_req got %b/%h exp 1/00", mem_req, mem_addr); end
    tick();
    #2 reset = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rerst_async got %b exp 0", mem_req); end
    @(negedge clock);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || {Opcode, Funct, operand} !== 8'hA5) begin miscompares++; $display("FAIL rerst_refetch got v%b pc%h ir%h exp v1 pc00 ira5", instr_valid, instr_pc, {Opcode, Funct, operand}); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_redirect();
    test_idle();
    test_timeout();
    test_reset_mid_request();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
